// File: rtl/main_fifo_pop_router.sv
// Read side of the main FIFO: pops words under almost-full backpressure and
// steers each word by its class bit (MSB) to the VC0 or VC1 FIFO.
module main_fifo_pop_router #(
  parameter int data_width = 6,
  parameter int cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  main_empty,
  input  logic [data_width-1:0] main_data,
  input  logic                  vc0_almost_full,
  input  logic                  vc1_almost_full,
  input  logic                  vc0_full,
  input  logic                  vc1_full,
  output logic                  main_rd_enable,
  output logic                  vc0_wr_enable,
  output logic                  vc1_wr_enable,
  output logic [data_width-1:0] vc_data_out,
  output logic [2:0]            state,
  output logic [cnt_width-1:0]  vc0_count,
  output logic [cnt_width-1:0]  vc1_count,
  output logic                  overflow_error
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_STALL  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_pending;
  logic                  r_vc0Wr;
  logic                  r_vc1Wr;
  logic [data_width-1:0] r_vcData;
  logic [cnt_width-1:0]  r_vc0Count;
  logic [cnt_width-1:0]  r_vc1Count;
  logic                  r_overflow;
  logic                  w_bp;
  logic                  w_rdEnable;
  logic                  w_isVc1;
  logic                  w_targetFull;

  // The destination is unknown until the word arrives, so either VC stalls the pop.
  assign w_bp         = vc0_almost_full | vc1_almost_full;
  assign w_isVc1      = main_data[data_width-1];
  assign w_targetFull = w_isVc1 ? vc1_full : vc0_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RESET;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_RESET) begin
      w_nextState = ST_INIT;
    end else if (!init) begin
      w_nextState = ST_INIT;
    end else begin
      case (r_state)
        ST_INIT:   w_nextState = ST_IDLE;
        ST_IDLE: begin
          if (!main_empty) w_nextState = w_bp ? ST_STALL : ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (main_empty) w_nextState = ST_IDLE;
          else if (w_bp)  w_nextState = ST_STALL;
        end
        ST_STALL: begin
          if (!w_bp) w_nextState = main_empty ? ST_IDLE : ST_ACTIVE;
        end
        default:   w_nextState = ST_INIT;
      endcase
    end
  end

  always_comb begin
    w_rdEnable = 1'b0;
    if (init && (r_state == ST_ACTIVE) && !main_empty && !w_bp) w_rdEnable = 1'b1;
  end

  // Routing stage: a word popped last cycle is on main_data now; register its write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending  <= 1'b0;
      r_vc0Wr    <= 1'b0;
      r_vc1Wr    <= 1'b0;
      r_vcData   <= '0;
      r_vc0Count <= '0;
      r_vc1Count <= '0;
      r_overflow <= 1'b0;
    end else if (!init) begin
      r_pending  <= 1'b0;
      r_vc0Wr    <= 1'b0;
      r_vc1Wr    <= 1'b0;
      r_vcData   <= '0;
      r_vc0Count <= '0;
      r_vc1Count <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= w_rdEnable;
      if (r_pending) begin
        r_vcData <= main_data;
        r_vc0Wr  <= ~w_isVc1;
        r_vc1Wr  <= w_isVc1;
        if (w_isVc1) r_vc1Count <= r_vc1Count + 1'b1;
        else         r_vc0Count <= r_vc0Count + 1'b1;
        if (w_targetFull) r_overflow <= 1'b1;
      end else begin
        r_vcData <= '0;
        r_vc0Wr  <= 1'b0;
        r_vc1Wr  <= 1'b0;
      end
    end
  end

  assign main_rd_enable = w_rdEnable;
  assign vc0_wr_enable  = r_vc0Wr;
  assign vc1_wr_enable  = r_vc1Wr;
  assign vc_data_out    = r_vcData;
  assign state          = r_state;
  assign vc0_count      = r_vc0Count;
  assign vc1_count      = r_vc1Count;
  assign overflow_error = r_overflow;

endmodule

// File: tb/tb_main_fifo_pop_router.sv
// Directed bench for main_fifo_pop_router with a behavioural main FIFO
// (one-cycle registered read) and per-VC write logs.
module tb_main_fifo_pop_router;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic       mainEmpty;
  logic [5:0] mainData = '0;
  logic       vc0AlmostFull;
  logic       vc1AlmostFull;
  logic       vc0Full;
  logic       vc1Full;
  logic       mainRdEnable;
  logic       vc0WrEnable;
  logic       vc1WrEnable;
  logic [5:0] vcDataOut;
  logic [2:0] state;
  logic [7:0] vc0Count;
  logic [7:0] vc1Count;
  logic       overflowError;

  int assertCount = 0;
  int failCount   = 0;

  logic [5:0] mem [0:511];
  int         wrPtr = 0;
  int         rdPtr = 0;
  logic [5:0] vc0Log [$];
  logic [5:0] vc1Log [$];

  main_fifo_pop_router #(.data_width(6), .cnt_width(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .main_empty      (mainEmpty),
    .main_data       (mainData),
    .vc0_almost_full (vc0AlmostFull),
    .vc1_almost_full (vc1AlmostFull),
    .vc0_full        (vc0Full),
    .vc1_full        (vc1Full),
    .main_rd_enable  (mainRdEnable),
    .vc0_wr_enable   (vc0WrEnable),
    .vc1_wr_enable   (vc1WrEnable),
    .vc_data_out     (vcDataOut),
    .state           (state),
    .vc0_count       (vc0Count),
    .vc1_count       (vc1Count),
    .overflow_error  (overflowError)
  );

  always #5 clk = ~clk;

  // Main FIFO model: data appears the cycle after a pop, 0 otherwise.
  assign mainEmpty = (rdPtr == wrPtr);
  always @(posedge clk) begin
    if (mainRdEnable) begin
      mainData <= mem[rdPtr[8:0]];
      rdPtr    <= rdPtr + 1;
    end else begin
      mainData <= '0;
    end
  end

  always @(negedge clk) begin
    if (vc0WrEnable) vc0Log.push_back(vcDataOut);
    if (vc1WrEnable) vc1Log.push_back(vcDataOut);
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] word);
    mem[wrPtr[8:0]] = word;
    wrPtr = wrPtr + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitLogs(input string tag, input int n0, input int n1);
    int budget;
    budget = 600;
    while ((vc0Log.size() < n0 || vc1Log.size() < n1) && budget > 0) begin
      tick(1);
      budget--;
    end
    tick(3);
    checkOutput({tag, "_vc0n"}, vc0Log.size(), n0);
    checkOutput({tag, "_vc1n"}, vc1Log.size(), n1);
  endtask

  initial begin
    int n0;
    int n1;
    reset = 1'b1; init = 1'b0;
    vc0AlmostFull = 1'b0; vc1AlmostFull = 1'b0; vc0Full = 1'b0; vc1Full = 1'b0;

    // 1: reset and init sequencing
    tick(2);
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_rd", int'(mainRdEnable), 0);
    checkOutput("rst_wr", int'({vc0WrEnable, vc1WrEnable}), 0);
    checkOutput("rst_data", int'(vcDataOut), 0);
    checkOutput("rst_cnt", int'({vc0Count, vc1Count}), 0);
    checkOutput("rst_ovf", int'(overflowError), 0);
    reset = 1'b0;
    tick(1);
    checkOutput("init_state", int'(state), 1);
    tick(1);
    checkOutput("init_hold", int'(state), 1);
    init = 1'b1;
    tick(1);
    checkOutput("idle_state", int'(state), 2);

    // 2: two words, one per VC, back-to-back pops
    applyStimulus(6'h05); applyStimulus(6'h25);
    tick(1);
    checkOutput("t2_rd1", int'(mainRdEnable), 1);
    checkOutput("t2_act", int'(state), 3);
    tick(1);
    checkOutput("t2_rd2", int'(mainRdEnable), 1);
    checkOutput("t2_wr0_early", int'(vc0WrEnable), 0);
    tick(1);
    checkOutput("t2_rd3", int'(mainRdEnable), 0);
    checkOutput("t2_wr0", int'(vc0WrEnable), 1);
    checkOutput("t2_wr1_n", int'(vc1WrEnable), 0);
    checkOutput("t2_data0", int'(vcDataOut), 6'h05);
    checkOutput("t2_cnt0", int'(vc0Count), 1);
    tick(1);
    checkOutput("t2_wr1", int'(vc1WrEnable), 1);
    checkOutput("t2_wr0_n", int'(vc0WrEnable), 0);
    checkOutput("t2_data1", int'(vcDataOut), 6'h25);
    checkOutput("t2_cnt1", int'(vc1Count), 1);
    checkOutput("t2_idle", int'(state), 2);
    tick(1);
    checkOutput("t2_wr_off", int'({vc0WrEnable, vc1WrEnable}), 0);
    checkOutput("t2_data_off", int'(vcDataOut), 0);

    // 3: backpressure after the second pop; in-flight word still completes
    applyStimulus(6'h01); applyStimulus(6'h22); applyStimulus(6'h03); applyStimulus(6'h24);
    tick(3);
    checkOutput("t3_wr0", int'(vc0WrEnable), 1);
    checkOutput("t3_data0", int'(vcDataOut), 6'h01);
    vc1AlmostFull = 1'b1;
    #1;
    checkOutput("t3_rd_drop", int'(mainRdEnable), 0);
    tick(1);
    checkOutput("t3_stall", int'(state), 4);
    checkOutput("t3_inflight_wr", int'(vc1WrEnable), 1);
    checkOutput("t3_inflight_data", int'(vcDataOut), 6'h22);
    tick(2);
    checkOutput("t3_stall_hold", int'(state), 4);
    checkOutput("t3_stall_rd", int'(mainRdEnable), 0);
    checkOutput("t3_stall_wr", int'({vc0WrEnable, vc1WrEnable}), 0);
    vc1AlmostFull = 1'b0;
    waitLogs("t3", 3, 3);
    checkOutput("t3_vc0_last", int'(vc0Log[2]), 6'h03);
    checkOutput("t3_vc1_last", int'(vc1Log[2]), 6'h24);
    checkOutput("t3_cnt0", int'(vc0Count), 3);
    checkOutput("t3_cnt1", int'(vc1Count), 3);
    checkOutput("t3_idle", int'(state), 2);

    // 4: write into a full VC sets the sticky error; init low clears it
    vc0Full = 1'b1;
    applyStimulus(6'h07);
    waitLogs("t4", 4, 3);
    checkOutput("t4_vc0_word", int'(vc0Log[3]), 6'h07);
    checkOutput("t4_ovf", int'(overflowError), 1);
    vc0Full = 1'b0;
    tick(2);
    checkOutput("t4_ovf_sticky", int'(overflowError), 1);
    checkOutput("t4_cnt0", int'(vc0Count), 4);
    init = 1'b0;
    tick(1);
    checkOutput("t4_ovf_clr", int'(overflowError), 0);
    checkOutput("t4_cnt_clr", int'({vc0Count, vc1Count}), 0);
    checkOutput("t4_init", int'(state), 1);
    init = 1'b1;
    tick(1);
    checkOutput("t4_idle", int'(state), 2);

    // 5: one VC1 word, then 256 VC0 words wrap the VC0 counter
    applyStimulus(6'h20);
    for (int i = 0; i < 128; i++) applyStimulus(6'(i % 32));
    waitLogs("t5a", 132, 4);
    checkOutput("t5_cnt0_half", int'(vc0Count), 128);
    checkOutput("t5_cnt1_half", int'(vc1Count), 1);
    for (int i = 0; i < 128; i++) applyStimulus(6'((i + 5) % 32));
    waitLogs("t5b", 260, 4);
    checkOutput("t5_cnt0_wrap", int'(vc0Count), 0);
    checkOutput("t5_cnt1", int'(vc1Count), 1);
    checkOutput("t5_last", int'(vc0Log[259]), 6'h04);
    checkOutput("t5_ovf", int'(overflowError), 0);

    // 6: asynchronous reset while a popped word is in flight
    n0 = vc0Log.size(); n1 = vc1Log.size();
    applyStimulus(6'h31);
    tick(1);
    checkOutput("t6_rd", int'(mainRdEnable), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_state", int'(state), 0);
    checkOutput("t6_async_cnt1", int'(vc1Count), 0);
    checkOutput("t6_async_rd", int'(mainRdEnable), 0);
    checkOutput("t6_async_wr", int'({vc0WrEnable, vc1WrEnable}), 0);
    tick(2);
    reset = 1'b0;
    tick(4);
    checkOutput("t6_idle", int'(state), 2);
    checkOutput("t6_no_vc0", vc0Log.size(), n0);
    checkOutput("t6_no_vc1", vc1Log.size(), n1);
    checkOutput("t6_cnt", int'({vc0Count, vc1Count}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/main_fifo_pop_router.md
Name: main_fifo_pop_router

Overview:
Read side of the main FIFO. Pops words from the main FIFO under flow control and routes each word by its class bit (MSB) to one of two virtual-channel FIFOs (VC0/VC1). It honours downstream almost-full backpressure and absorbs the main FIFO's one-cycle registered read latency. It sits between the main FIFO's read port and the VC FIFO write ports in the transmission path.

Parameters:
data_width, 6, word width; must match the main FIFO and VC FIFOs.
cnt_width, 8, width of the per-VC routed-word counters.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
init  input  1  0 = hold in INIT (all outputs idle); 1 = normal operation.
main_empty  input  1  main FIFO empty flag.
main_data  input  data_width  main FIFO data_out; valid the cycle after main_rd_enable=1.
vc0_almost_full  input  1  VC0 almost-full flag.
vc1_almost_full  input  1  VC1 almost-full flag.
vc0_full  input  1  VC0 full flag.
vc1_full  input  1  VC1 full flag.
main_rd_enable  output  1  pop request to the main FIFO.
vc0_wr_enable  output  1  write strobe to VC0.
vc1_wr_enable  output  1  write strobe to VC1.
vc_data_out  output  data_width  data to both VC FIFOs.
state  output  3  FSM state encoding.
vc0_count  output  cnt_width  words routed to VC0 (wraps).
vc1_count  output  cnt_width  words routed to VC1 (wraps).
overflow_error  output  1  sticky flag: a write was presented to a full VC.

Behaviour:
- reset=1 (async): state=RESET(0); main_rd_enable, vc0/vc1_wr_enable, vc_data_out, vc0/vc1_count, overflow_error=0; pending=0.
- FSM states, all registered: RESET=0, INIT=1, IDLE=2, ACTIVE=3, STALL=4.
- RESET -> INIT on the first clock after reset deasserts.
- From any state other than RESET, init=0 -> INIT on the next edge. Counters, error and pending all clear, and all outputs are driven 0.
- INIT -> IDLE when init=1.
- Let bp = vc0_almost_full | vc1_almost_full. The destination is unknown before the pop, so either almost-full stalls the pop.
- IDLE: main_empty=0 and bp=0 -> ACTIVE; main_empty=0 and bp=1 -> STALL.
- ACTIVE: main_empty=1 -> IDLE; bp=1 -> STALL; otherwise stay.
- STALL: bp=0 -> ACTIVE if main_empty=0, else IDLE.
- main_rd_enable is combinational: 1 only when state=ACTIVE, main_empty=0 and bp=0. It allows one pop per cycle with no gaps.
- pending is a register: it takes the value of main_rd_enable on every edge.
- Routing when pending=1, registered so routing latency is 1 cycle after the data appears:
  - vc_data_out <= main_data.
  - main_data[data_width-1]=0 -> vc0_wr_enable<=1; =1 -> vc1_wr_enable<=1.
  - The matching count increments, wrapping modulo 2^cnt_width.
- When pending=0: both wr_enables <= 0 and vc_data_out <= 0.
- End-to-end, pop to VC write is 2 cycles.
- An in-flight word (pending=1) always completes routing, even if the state moves to STALL or IDLE that cycle.
- Almost-full thresholds must be >=2 so one in-flight plus one routing word fit.
- If a routed write targets a VC whose full=1 at that edge: overflow_error <= 1 (sticky until reset or init=0). The write strobe is still issued.
- init falling while pending=1: the word is dropped, no VC write occurs, and the count is not changed.
- main_data is ignored whenever pending=0; the FIFO drives 0 there.

Test Plan:
1. Reset=1, then release with init=0 -> state=INIT, all outputs 0. Raise init -> state=IDLE next edge.
2. Main FIFO holds 0x05, 0x25 (data_width 6); no backpressure -> rd_enable high 2 consecutive cycles. Two cycles later: vc0_wr with 0x05, then vc1_wr with 0x25. vc0_count=1, vc1_count=1. state returns to IDLE.
3. Stream 4 words, vc1_almost_full asserted after 2nd pop -> rd_enable drops same cycle, state=STALL. The in-flight word still writes. Deassert -> remaining 2 words routed in order.
4. Route a word to VC0 while vc0_full=1 -> write strobe issued, overflow_error=1 and held. init 1->0 -> overflow_error=0.
5. 256 VC0 words -> vc0_count wraps to 0; vc1_count unchanged.
6. Assert reset asynchronously mid-stream with pending=1 -> outputs 0 immediately without a clock edge. No VC write occurs after release.
